// File: rtl/comb_resp_misr.sv
// MISR response compactor for the mapped b9 combinational core.
// Optional golden-signature comparator enabled by defining MISR_GOLDEN_CMP_EN.
module comb_resp_misr #(
    parameter int          WIDTH = 21,
    parameter int          SIG_W = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter logic [31:0] SEED  = 32'hFFFFFFFF,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
`ifdef MISR_GOLDEN_CMP_EN
    input  logic [SIG_W-1:0] golden,
    output logic             pass,
`endif
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SIG_W-1:0] seed_w;
    logic [SIG_W-1:0] poly_w;

    assign seed_w = SIG_W'(SEED);
    assign poly_w = SIG_W'(POLY);

    // Wide responses wrap around the register; narrow ones are zero-extended.
    always_comb begin
        fold = '0;
        for (int i = 0; i < WIDTH; i++)
            fold[i % SIG_W] = fold[i % SIG_W] ^ resp_data[i];
    end

    assign sig_nxt = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? poly_w : '0)
                   ^ fold;
    assign cnt_nxt = vec_count + 1'b1;

    assign resp_ready = (state == RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            signature <= '0;
            vec_count <= '0;
            target    <= '0;
`ifdef MISR_GOLDEN_CMP_EN
            pass      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        signature <= seed_w;
                        vec_count <= '0;
                        target    <= num_vec;
                        if (num_vec != '0) begin
                            state <= RUN;
`ifdef MISR_GOLDEN_CMP_EN
                            pass  <= 1'b0;
`endif
                        end else begin
                            state <= DONE;
`ifdef MISR_GOLDEN_CMP_EN
                            pass  <= (seed_w == golden);
`endif
                        end
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        signature <= sig_nxt;
                        vec_count <= cnt_nxt;
                        if (cnt_nxt == target) begin
                            state <= DONE;
`ifdef MISR_GOLDEN_CMP_EN
                            pass  <= (sig_nxt == golden);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
